countdown_ctrl: RTL and testbench
=================================

// Module: countdown_ctrl
// PURPOSE
// Control FSM for the seconds-timer display path: debounces start/pause and clear buttons,
// generates the 1 Hz tick from clk and runs a BCD seconds countdown from a preset to 00.
// Feeds secTens/secOnes to the seven-segment driver (segEn/seg); running/expired drive LEDs.
// PARAMETERS
// TICK_DIV    100_000_000  clk cycles per counted second (>=2)
// DEB_CYCLES  1_000_000    consecutive stable cycles required to accept a button level (>=1)
// PRESET_SEC  60           countdown start value, decimal 0..99
// PORTS
// clk       in   1  system clock, all logic on rising edge
// btnC      in   1  reset: synchronous, active-high
// btnU      in   1  raw start/pause button, async, active-high
// btnD      in   1  raw clear button, async, active-high
// secTens   out  4  BCD tens digit of remaining seconds
// secOnes   out  4  BCD ones digit of remaining seconds
// running   out  1  high while state==RUN
// expired   out  1  high while state==DONE
// tick      out  1  1-cycle pulse on each counted second (RUN only)
// BEHAVIOUR
// - Reset (btnC=1 at clk edge, any state): state=IDLE, digits=PRESET_SEC, tick=0, running=0,
//   expired=0, prescaler=0, debounce counters=0, stable levels=0; takes effect next cycle.
// - Debounce per button: 2-flop synchronizer -> stable level changes once sync output has differed
//   from it for DEB_CYCLES consecutive cycles (any agreeing cycle clears the counter).
//   Press pulse (startP/clearP) = 1 cycle, in the cycle the stable level goes 0->1. Release ignored.
//   Button held through reset -> one press DEB_CYCLES(+sync) after reset release.
// - States: IDLE (digits=preset), RUN, PAUSE, DONE (digits=00).
//   IDLE +startP -> RUN, prescaler cleared (if PRESET_SEC==0: -> DONE instead).
//   RUN  +startP -> PAUSE; PAUSE +startP -> RUN. DONE ignores startP.
//   Any state +clearP -> IDLE, digits reload preset, prescaler=0.
//   Same-cycle startP and clearP: clear wins.
// - Prescaler: counts 0..TICK_DIV-1 only in RUN, wraps to 0; held (not cleared) in PAUSE so
//   resume completes the partial second. tick=1 in the cycle prescaler==TICK_DIV-1 in RUN.
// - On tick: BCD decrement registered same edge (visible next cycle). ones 0 -> 9 with tens-1.
//   If digits==01 on tick: digits -> 00 and state -> DONE; tick pulse still emitted.
// - Tick and startP same cycle in RUN: decrement applied and state -> PAUSE.
//   Tick and clearP same cycle: clear wins, no decrement.
// - Digits never wrap below 00; BCD values always 0..9; outputs all registered, no comb paths.
// TESTING (bench params: TICK_DIV=10, DEB_CYCLES=4, PRESET_SEC=12)
// 1 Reset: btnC=1 2 cycles -> secTens=1 secOnes=2, running=0 expired=0 tick=0.
// 2 Bounce: btnU toggled every 2 cycles for 20 cycles then low -> no press, state stays IDLE;
//   btnU held 10 cycles -> exactly one startP, running=1 ~7 cycles after rise.
// 3 Countdown: start, run -> tick every 10 cycles; digits 12,11,10,09..01,00; expired=1 at 00,
//   running=0, no further ticks; 12 ticks total.
// 4 Pause/resume: start, pause 5 cycles into a second, hold 50 cycles -> no ticks, digits frozen;
//   resume -> next tick exactly 5 cycles after resume press.
// 5 Collisions: startP and clearP same cycle in RUN -> IDLE digits=12; tick+startP same cycle ->
//   digits decrement once and running=0.
// 6 Reset mid-run at digits=07 -> next cycle digits=12, state IDLE, prescaler 0, tick=0.

Source files
------------

// File: rtl/countdown_ctrl.sv
// Seconds countdown controller: button debounce, 1 Hz prescaler,
// BCD countdown FSM driving the display digits and status LEDs.

module countdown_deb #(
  parameter int DEB_CYCLES = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_press
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] LAST = DW'(DEB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stb;
  logic          r_stb_d;
  logic [DW-1:0] r_cnt;

  // Synchronize raw level, accept a new level after a full stable run
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_stb   <= 1'b0;
      r_stb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_stb_d <= r_stb;
      if (r_s2 == r_stb) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_stb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DW'(1);
      end
    end
  end

  assign o_press = r_stb & ~r_stb_d;

endmodule

module countdown_ctrl #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int PRESET_SEC = 60
) (
  input  logic       clk,
  input  logic       btnC,
  input  logic       btnU,
  input  logic       btnD,
  output logic [3:0] secTens,
  output logic [3:0] secOnes,
  output logic       running,
  output logic       expired,
  output logic       tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0] P_TENS = 4'(PRESET_SEC / 10);
  localparam logic [3:0] P_ONES = 4'(PRESET_SEC % 10);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic [3:0]    r_tens;
  logic [3:0]    r_ones;
  logic [3:0]    w_tens_nxt;
  logic [3:0]    w_ones_nxt;
  logic          w_startP;
  logic          w_clearP;
  logic          w_tick;
  logic          w_last_sec;

  countdown_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .i_clk   (clk),
    .i_rst   (btnC),
    .i_raw   (btnU),
    .o_press (w_startP)
  );

  countdown_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .i_clk   (clk),
    .i_rst   (btnC),
    .i_raw   (btnD),
    .o_press (w_clearP)
  );

  assign w_tick     = (r_state == S_RUN) && (r_presc == P_LAST);
  assign w_last_sec = (r_tens == 4'd0) && (r_ones == 4'd1);

  // Next state, prescaler and BCD digits; clear overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    if (w_clearP) begin
      w_state_nxt = S_IDLE;
      w_presc_nxt = '0;
      w_tens_nxt  = P_TENS;
      w_ones_nxt  = P_ONES;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_startP) begin
            w_presc_nxt = '0;
            w_state_nxt = (PRESET_SEC == 0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_startP) begin
            w_state_nxt = S_PAUSE;
          end
          if (w_tick) begin
            w_presc_nxt = '0;
            if (r_ones != 4'd0) begin
              w_ones_nxt = r_ones - 4'd1;
            end else if (r_tens != 4'd0) begin
              w_ones_nxt = 4'd9;
              w_tens_nxt = r_tens - 4'd1;
            end
            if (w_last_sec) begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
        end
        S_PAUSE: begin
          if (w_startP) begin
            w_state_nxt = S_RUN;
          end
        end
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, prescaler and digit registers with synchronous reset
  always_ff @(posedge clk) begin
    if (btnC) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_tens  <= P_TENS;
      r_ones  <= P_ONES;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_tens  <= w_tens_nxt;
      r_ones  <= w_ones_nxt;
    end
  end

  assign secTens = r_tens;
  assign secOnes = r_ones;
  assign running = (r_state == S_RUN);
  assign expired = (r_state == S_DONE);
  assign tick    = w_tick;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl against a seconds-level
// reference model (integer remaining seconds, run-length debounce).

module tb_countdown_ctrl;

  localparam int TD = 10;
  localparam int DB = 4;
  localparam int PS = 12;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       btnC = 1'b1;
  logic       btnU = 1'b0;
  logic       btnD = 1'b0;
  logic [3:0] secTens;
  logic [3:0] secOnes;
  logic       running;
  logic       expired;
  logic       tick;

  always #5 clk = ~clk;

  countdown_ctrl #(
    .TICK_DIV   (TD),
    .DEB_CYCLES (DB),
    .PRESET_SEC (PS)
  ) dut (
    .clk     (clk),
    .btnC    (btnC),
    .btnU    (btnU),
    .btnD    (btnD),
    .secTens (secTens),
    .secOnes (secOnes),
    .running (running),
    .expired (expired),
    .tick    (tick)
  );

  typedef struct {
    int cyc;
    int dig;
  } exp_t;

  exp_t sbq[$];

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int n_ticks = 0;
  int lt_cyc = 0;

  int m_mode = M_IDLE;
  int m_rem = PS;
  int m_ph = 0;
  int du0 = 0, du1 = 0, st_u = 0, rl_u = 0;
  int dd0 = 0, dd1 = 0, st_d = 0, rl_d = 0;
  bit pend_u = 0, pend_d = 0;

  function automatic int dig();
    return int'(secTens) * 10 + int'(secOnes);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string name);
    chk({name, " digits"}, dig(), m_rem);
    chk({name, " running"}, int'(running), int'(m_mode == M_RUN));
    chk({name, " expired"}, int'(expired), int'(m_mode == M_DONE));
  endtask

  // Debounce rule: level accepted after DB consecutive disagreeing samples
  task automatic deb(input int raw, inout int d0, inout int d1,
                     inout int st, inout int rl, output bit press);
    int seen;
    seen = d1;
    d1 = d0;
    d0 = raw;
    press = 0;
    if (seen != st) begin
      rl++;
      if (rl == DB) begin
        st = seen;
        rl = 0;
        press = (seen == 1);
      end
    end else begin
      rl = 0;
    end
  endtask

  task automatic model_edge(input bit u, input bit d, input bit c);
    bit tk;
    bit pu;
    bit pd;
    tk = (m_mode == M_RUN) && (m_ph == TD - 1);
    if (c) begin
      m_mode = M_IDLE;
      m_rem = PS;
      m_ph = 0;
      du0 = 0; du1 = 0; st_u = 0; rl_u = 0;
      dd0 = 0; dd1 = 0; st_d = 0; rl_d = 0;
      pend_u = 0;
      pend_d = 0;
    end else begin
      if (pend_d) begin
        m_mode = M_IDLE;
        m_rem = PS;
        m_ph = 0;
      end else begin
        case (m_mode)
          M_IDLE: if (pend_u) begin
            m_mode = (PS == 0) ? M_DONE : M_RUN;
            m_ph = 0;
          end
          M_RUN: begin
            if (tk) begin
              m_ph = 0;
              if (m_rem > 0) m_rem--;
            end else begin
              m_ph++;
            end
            if (tk && m_rem == 0) m_mode = M_DONE;
            else if (pend_u) m_mode = M_PAUSE;
          end
          M_PAUSE: if (pend_u) m_mode = M_RUN;
          default: ;
        endcase
      end
      deb(int'(u), du0, du1, st_u, rl_u, pu);
      deb(int'(d), dd0, dd1, st_d, rl_d, pd);
      pend_u = pu;
      pend_d = pd;
    end
    if (tk) sbq.push_back('{cyc_n, m_rem});
  endtask

  task automatic step(input bit u, input bit d, input bit c);
    btnU = u;
    btnD = d;
    btnC = c;
    @(posedge clk);
    model_edge(u, d, c);
    cyc_n++;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask

  task automatic press(input bit u, input bit d, input int hold);
    repeat (hold) step(u, d, 0);
  endtask

  // Monitor: every DUT tick pops one expectation (cycle and next digits)
  initial begin
    bit   pnd;
    int   pcyc;
    exp_t e;
    pnd = 0;
    pcyc = 0;
    forever begin
      @(negedge clk);
      if (pnd) begin
        pnd = 0;
        chk("tick expected", int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("tick cycle", pcyc, e.cyc);
          chk("tick digits", dig(), e.dig);
        end
      end
      if (tick === 1'b1) begin
        pnd = 1;
        pcyc = cyc_n;
        lt_cyc = cyc_n;
        n_ticks++;
      end
    end
  end

  initial begin
    int t0;
    int r;
    int dbf;
    int k;
    int act;
    @(negedge clk);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("reset digits", dig(), 12);
    chk("reset running", int'(running), 0);
    chk("reset expired", int'(expired), 0);
    chk("reset tick", int'(tick), 0);
    idle(3);

    for (int i = 0; i < 20; i++) step(((i / 2) % 2) == 0, 0, 0);
    idle(10);
    chk("bounce no start", int'(running), 0);
    chk_model("bounce");

    t0 = n_ticks;
    repeat (6) step(1, 0, 0);
    chk("start early", int'(running), 0);
    step(1, 0, 0);
    chk("start latency", int'(running), 1);
    repeat (3) step(1, 0, 0);
    for (k = 0; k < 300 && expired !== 1'b1; k++) step(0, 0, 0);
    chk("countdown expired", int'(expired), 1);
    chk("countdown running", int'(running), 0);
    chk("countdown digits", dig(), 0);
    idle(30);
    chk("countdown ticks", n_ticks - t0, 12);
    chk_model("done");

    press(0, 1, 6);
    idle(8);
    chk("clear digits", dig(), 12);
    chk("clear expired", int'(expired), 0);
    press(1, 0, 6);
    idle(8);
    chk("restart running", int'(running), 1);
    for (k = 0; k < 30 &&
         !(m_mode == M_RUN && m_ph == ((4 - (DB + 2)) % TD + TD) % TD);
         k++) step(0, 0, 0);
    chk("pause align", int'(k < 30), 1);
    press(1, 0, 6);
    idle(2);
    t0 = n_ticks;
    dbf = m_rem;
    idle(50);
    chk("pause running", int'(running), 0);
    chk("pause ticks", n_ticks - t0, 0);
    chk("pause digits", dig(), dbf);
    r = cyc_n;
    t0 = n_ticks;
    press(1, 0, 6);
    for (k = 0; k < 30 && n_ticks == t0; k++) step(0, 0, 0);
    chk("resume tick offset", lt_cyc - r, DB + 2 + 5);
    idle(8);

    press(1, 1, 6);
    idle(3);
    chk("start+clear running", int'(running), 0);
    chk("start+clear digits", dig(), 12);
    chk_model("start+clear");

    idle(8);
    press(1, 0, 6);
    idle(8);
    for (k = 0; k < 30 && !(m_mode == M_RUN && m_ph == 3); k++)
      step(0, 0, 0);
    chk("tick+start align", int'(k < 30), 1);
    dbf = m_rem;
    press(1, 0, 6);
    idle(1);
    chk("tick+start running", int'(running), 0);
    chk("tick+start digits", dig(), dbf - 1);
    chk_model("tick+start");

    idle(8);
    press(1, 0, 6);
    for (k = 0; k < 200 && m_rem != 7; k++) step(0, 0, 0);
    chk("mid-run digits", dig(), 7);
    step(0, 0, 1);
    chk("mid-run reset digits", dig(), 12);
    chk("mid-run reset running", int'(running), 0);
    chk("mid-run reset tick", int'(tick), 0);
    press(1, 0, 6);
    idle(25);
    chk_model("post-reset run");

    for (int s = 0; s < 40; s++) begin
      act = int'($urandom_range(0, 5));
      case (act)
        0: idle(int'($urandom_range(1, 25)));
        1: press(1, 0, int'($urandom_range(3, 9)));
        2: press(0, 1, int'($urandom_range(3, 9)));
        3: for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 0, 0);
        4: press(1, 1, int'($urandom_range(3, 9)));
        default: if ($urandom_range(0, 3) == 0) step(0, 0, 1);
      endcase
      idle(int'($urandom_range(0, 6)));
      chk_model("random");
    end

    step(0, 0, 1);
    idle(4);
    chk("scoreboard drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
